draw_rectangle_gen: RTL and testbench



---
 rtl/draw_rectangle_gen_if.sv | 27 ++
 rtl/draw_rectangle_gen.sv | 189 ++++++++++++++++++
 tb/tb_draw_rectangle_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/draw_rectangle_gen_if.sv
// Bundles the request, geometry and point-stream signals of the
// rectangle outline generator into one port.
// The slave modport faces the generator.
// The master modport faces whoever issues requests and consumes points.
interface draw_rectangle_gen_if #(
   parameter int DW = 32
);
   logic                 _start;
   logic signed [DW-1:0] s_x;
   logic signed [DW-1:0] s_y;
   logic signed [DW-1:0] height;
   logic signed [DW-1:0] width;
   logic signed [DW-1:0] _out0;
   logic signed [DW-1:0] _out1;
   logic                 _valid;
   logic                 _done;

   modport master (
      output _start, s_x, s_y, height, width,
      input  _out0, _out1, _valid, _done
   );

   modport slave (
      input  _start, s_x, s_y, height, width,
      output _out0, _out1, _valid, _done
   );
endinterface

// File: rtl/draw_rectangle_gen.sv
// Rectangle outline point generator.
//
// Emits the outline points of a rectangle, one point per clock. The
// ROWS phase walks the y extent and emits the top and bottom edges
// as pairs. The COLS phase then walks the x extent and emits the left
// and right edges as pairs. A non-positive extent skips its phase.
// Corner points are emitted again where the phases overlap.
//
// The geometry is latched when a start request is accepted, so the
// inputs may change freely while a sequence runs. Outputs are
// registered. The first point appears the cycle after the accepting
// edge. The outputs keep their last value whenever _valid is low.
//
// Optional feature: define DRAW_RECTANGLE_RESTART_EN to let a start
// request during ROWS/COLS abort the running sequence and restart it
// with the new geometry. When the macro is not defined, such a request
// is ignored.
module draw_rectangle_gen #(
   parameter int DW = 32
) (
   input logic                  _clock,
   input logic                  _reset,
   draw_rectangle_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROWS = 2'd1,
      COLS = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   state_t        state_reg, state_next;
   logic [DW-1:0] i_reg,     i_next;
   logic          phase_reg, phase_next;
   logic [DW-1:0] x_reg,     x_next;
   logic [DW-1:0] y_reg,     y_next;
   logic [DW-1:0] h_reg,     h_next;
   logic [DW-1:0] w_reg,     w_next;
   logic [DW-1:0] out0_reg,  out0_next;
   logic [DW-1:0] out1_reg,  out1_next;
   logic          valid_reg, valid_next;
   logic          done_reg,  done_next;
   logic          start_ok;
   logic          accept;

   // A two's-complement value is strictly positive when its sign bit
   // is clear and it is not zero.
   function automatic logic is_pos(input logic [DW-1:0] v);
      return !v[DW-1] && (|v);
   endfunction

   // State, latched geometry and registered outputs; reset clears everything at once
   always_ff @(posedge _clock or posedge _reset) begin
      if (_reset) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         phase_reg <= 1'b0;
         x_reg     <= '0;
         y_reg     <= '0;
         h_reg     <= '0;
         w_reg     <= '0;
         out0_reg  <= '0;
         out1_reg  <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         phase_reg <= phase_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         h_reg     <= h_next;
         w_reg     <= w_next;
         out0_reg  <= out0_next;
         out1_reg  <= out1_next;
         valid_reg <= valid_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic: accept a request, or step to the next point of the outline
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      phase_next = phase_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      h_next     = h_reg;
      w_next     = w_reg;
      out0_next  = out0_reg;
      out1_next  = out1_reg;
      valid_next = 1'b0;
      done_next  = done_reg;

`ifdef DRAW_RECTANGLE_RESTART_EN
      start_ok = 1'b1;
`else
      start_ok = (state_reg == IDLE) || (state_reg == DONE);
`endif
      accept = bus._start && start_ok;

      if (accept) begin
         // Latch the geometry and present the first point straight from
         // the inputs. ROWS and COLS both begin at (s_x, s_y).
         x_next     = bus.s_x;
         y_next     = bus.s_y;
         h_next     = bus.height;
         w_next     = bus.width;
         i_next     = '0;
         phase_next = 1'b0;
         done_next  = 1'b0;
         if (is_pos(bus.width)) begin
            state_next = ROWS;
            out0_next  = bus.s_x;
            out1_next  = bus.s_y;
            valid_next = 1'b1;
         end else if (is_pos(bus.height)) begin
            state_next = COLS;
            out0_next  = bus.s_x;
            out1_next  = bus.s_y;
            valid_next = 1'b1;
         end else begin
            // Empty rectangle: signal completion without any points.
            state_next = DONE;
            done_next  = 1'b1;
         end
      end else begin
         // state/i/phase identify the point currently on the outputs.
         // Each cycle advances to the next point.
         case (state_reg)
            ROWS: begin
               if (!phase_reg) begin
                  phase_next = 1'b1;
                  out0_next  = x_reg + h_reg - ONE;
                  out1_next  = y_reg + i_reg;
                  valid_next = 1'b1;
               end else if (i_reg != w_reg - ONE) begin
                  i_next     = i_reg + ONE;
                  phase_next = 1'b0;
                  out0_next  = x_reg;
                  out1_next  = y_reg + i_reg + ONE;
                  valid_next = 1'b1;
               end else if (is_pos(h_reg)) begin
                  state_next = COLS;
                  i_next     = '0;
                  phase_next = 1'b0;
                  out0_next  = x_reg;
                  out1_next  = y_reg;
                  valid_next = 1'b1;
               end else begin
                  state_next = DONE;
                  phase_next = 1'b0;
                  done_next  = 1'b1;
               end
            end
            COLS: begin
               if (!phase_reg) begin
                  phase_next = 1'b1;
                  out0_next  = x_reg + i_reg;
                  out1_next  = y_reg + w_reg - ONE;
                  valid_next = 1'b1;
               end else if (i_reg != h_reg - ONE) begin
                  i_next     = i_reg + ONE;
                  phase_next = 1'b0;
                  out0_next  = x_reg + i_reg + ONE;
                  out1_next  = y_reg;
                  valid_next = 1'b1;
               end else begin
                  state_next = DONE;
                  phase_next = 1'b0;
                  done_next  = 1'b1;
               end
            end
            default: begin
               // IDLE and DONE hold everything until a request arrives.
            end
         endcase
      end
   end

   assign bus._out0  = out0_reg;
   assign bus._out1  = out1_reg;
   assign bus._valid = valid_reg;
   assign bus._done  = done_reg;

endmodule

// File: tb/tb_draw_rectangle_gen.sv
// Bench for draw_rectangle_gen.
// It uses a table of directed rectangles and randomized rectangles,
// all checked against a list-of-points reference model.
// It also runs hand-written sequences for hold, reset abort and
// start-while-busy.
module tb_draw_rectangle_gen;
   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
   } pt_t;

   typedef struct {
      logic [31:0] sx;
      logic [31:0] sy;
      logic [31:0] h;
      logic [31:0] w;
      int          exp_n;
      pt_t         exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   pt_t  exp_q[$];
   pt_t  hold_pt;

   always #5 clk = ~clk;

   draw_rectangle_gen_if #(.DW(DW)) bus ();

   draw_rectangle_gen #(.DW(DW)) dut (
      ._clock (clk),
      ._reset (rst),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Outline as a plain list: top/bottom pairs across the width, then
   // left/right pairs down the height. The arithmetic wraps at 32 bits.
   function automatic void build_model(input logic [31:0] sx, input logic [31:0] sy,
                                       input logic [31:0] h, input logic [31:0] w);
      pt_t p;
      exp_q.delete();
      for (int i = 0; i < $signed(w); i++) begin
         p.x = sx;          p.y = sy + 32'(i); exp_q.push_back(p);
         p.x = sx + h - 1;  p.y = sy + 32'(i); exp_q.push_back(p);
      end
      for (int i = 0; i < $signed(h); i++) begin
         p.x = sx + 32'(i); p.y = sy;          exp_q.push_back(p);
         p.x = sx + 32'(i); p.y = sy + w - 1;  exp_q.push_back(p);
      end
   endfunction

   task automatic pulse_start(input logic [31:0] sx, input logic [31:0] sy,
                              input logic [31:0] h, input logic [31:0] w);
      @(negedge clk);
      bus._start = 1'b1;
      bus.s_x    = sx;
      bus.s_y    = sy;
      bus.height = h;
      bus.width  = w;
   endtask

   // Sample exp_q[from..upto-1], one point per cycle.
   // The inputs are scrambled each cycle to show they are not re-sampled.
   task automatic expect_points(input int from, input int upto, output int n_obs, output pt_t last_obs);
      pt_t got;
      n_obs    = 0;
      last_obs = hold_pt;
      for (int k = from; k < upto; k++) begin
         @(negedge clk);
         bus._start = 1'b0;
         bus.s_x    = $urandom;
         bus.s_y    = $urandom;
         bus.height = $urandom;
         bus.width  = $urandom;
         got.x = bus._out0;
         got.y = bus._out1;
         check($sformatf("valid_pt%0d", k), 64'(bus._valid), 64'(1));
         check($sformatf("done_low_pt%0d", k), 64'(bus._done), 64'(0));
         check($sformatf("point%0d", k), got, exp_q[k]);
         if (bus._valid) begin
            n_obs++;
            last_obs = got;
         end
         hold_pt = exp_q[k];
      end
   endtask

   task automatic expect_done(input string tag);
      pt_t got;
      @(negedge clk);
      bus._start = 1'b0;
      got.x = bus._out0;
      got.y = bus._out1;
      check({tag, "_end_valid"}, 64'(bus._valid), 64'(0));
      check({tag, "_end_done"}, 64'(bus._done), 64'(1));
      check({tag, "_end_hold"}, got, hold_pt);
   endtask

   task automatic run_rect(input logic [31:0] sx, input logic [31:0] sy,
                           input logic [31:0] h, input logic [31:0] w,
                           output int n_obs, output pt_t last_obs);
      build_model(sx, sy, h, w);
      pulse_start(sx, sy, h, w);
      expect_points(0, exp_q.size(), n_obs, last_obs);
      expect_done("rect");
      $display("rect sx=%0d sy=%0d h=%0d w=%0d points=%0d", $signed(sx), $signed(sy),
               $signed(h), $signed(w), n_obs);
   endtask

   vec_t vecs[5];

   initial begin
      int  n;
      pt_t last;
      pt_t got;

      vecs[0] = '{sx: 32'd1, sy: 32'd2, h: 32'd3, w: 32'd4, exp_n: 14, exp_last: '{x: 32'd3, y: 32'd5}};
      vecs[1] = '{sx: 32'd5, sy: 32'd5, h: 32'd0, w: 32'd2, exp_n: 4,  exp_last: '{x: 32'd4, y: 32'd6}};
      vecs[2] = '{sx: 32'd9, sy: 32'd9, h: 32'd0, w: 32'd0, exp_n: 0,  exp_last: '{x: 32'd0, y: 32'd0}};
      vecs[3] = '{sx: 32'd0, sy: 32'h7FFF_FFFF, h: 32'd1, w: 32'd2, exp_n: 6,
                  exp_last: '{x: 32'd0, y: 32'h8000_0000}};
      vecs[4] = '{sx: 32'd3, sy: 32'd3, h: 32'd2, w: 32'hFFFF_FFFF, exp_n: 4,
                  exp_last: '{x: 32'd4, y: 32'd1}};

      rst        = 1'b1;
      bus._start = 1'b0;
      bus.s_x    = '0;
      bus.s_y    = '0;
      bus.height = '0;
      bus.width  = '0;
      hold_pt    = '0;
      repeat (3) @(negedge clk);
      got.x = bus._out0;
      got.y = bus._out1;
      check("reset_out", got, 64'(0));
      check("reset_valid", 64'(bus._valid), 64'(0));
      check("reset_done", 64'(bus._done), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int v = 0; v < 5; v++) begin
         run_rect(vecs[v].sx, vecs[v].sy, vecs[v].h, vecs[v].w, n, last);
         check($sformatf("vec%0d_count", v), 64'(n), 64'(vecs[v].exp_n));
         if (vecs[v].exp_n > 0)
            check($sformatf("vec%0d_last", v), last, vecs[v].exp_last);
      end

      // Long hold after completion
      run_rect(32'd1, 32'd2, 32'd3, 32'd4, n, last);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         got.x = bus._out0;
         got.y = bus._out1;
         check($sformatf("hold%0d", c), {got, 1'b0, bus._valid, bus._done},
               {hold_pt, 1'b0, 1'b0, 1'b1});
      end

      // Reset after the fifth point aborts, then a fresh run is complete
      build_model(32'd1, 32'd2, 32'd3, 32'd4);
      pulse_start(32'd1, 32'd2, 32'd3, 32'd4);
      expect_points(0, 5, n, last);
      rst = 1'b1;
      #1;
      got.x = bus._out0;
      got.y = bus._out1;
      check("abort_out", got, 64'(0));
      check("abort_valid", 64'(bus._valid), 64'(0));
      check("abort_done", 64'(bus._done), 64'(0));
      hold_pt = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("after_abort_quiet", {bus._valid, bus._done}, 64'(0));
      end
      $display("reset abort after 5 points");
      run_rect(32'd1, 32'd2, 32'd3, 32'd4, n, last);
      check("rerun_count", 64'(n), 64'(14));

      // Start request while the third point is out
      build_model(32'd1, 32'd2, 32'd3, 32'd4);
      pulse_start(32'd1, 32'd2, 32'd3, 32'd4);
      expect_points(0, 3, n, last);
      bus._start = 1'b1;
      bus.s_x    = 32'd0;
      bus.s_y    = 32'd2;
      bus.height = 32'd3;
      bus.width  = 32'd4;
`ifdef DRAW_RECTANGLE_RESTART_EN
      build_model(32'd0, 32'd2, 32'd3, 32'd4);
      expect_points(0, 14, n, last);
      check("restart_count", 64'(n), 64'(14));
`else
      expect_points(3, 14, n, last);
      check("ignored_restart_count", 64'(n), 64'(11));
`endif
      expect_done("restart");
      $display("start while busy, remaining points=%0d", n);

      // Randomized rectangles
      for (int r = 0; r < 20; r++) begin
         logic [31:0] sx, sy, h, w;
         sx = $urandom;
         sy = $urandom;
         h  = 32'($signed($urandom_range(0, 10)) - 3);
         w  = 32'($signed($urandom_range(0, 10)) - 3);
         build_model(sx, sy, h, w);
         run_rect(sx, sy, h, w, n, last);
         check($sformatf("rand%0d_count", r), 64'(n),
               64'(2 * (($signed(w) > 0) ? $signed(w) : 0) + 2 * (($signed(h) > 0) ? $signed(h) : 0)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end
endmodule
